// File: rtl/aes_key_expand_seq.sv
// Iterative AES key-schedule generator: one 32-bit schedule word per clock,
// presented as the flattened round-key vector the cipher core consumes.

module aes_sbox32 (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    dout = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      dout[8*b +: 8] = SBOX[2047 - 8*int'(din[8*b +: 8]) -: 8];
    end
  end
endmodule

module aes_key_expand_seq #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [32*NK-1:0]        key,
  output logic [128*(NR+1)-1:0]   ExpandedKeys,
  output logic                    busy,
  output logic                    done
);
  localparam int TOTAL = 4*(NR+1);
  localparam int IW    = $clog2(TOTAL);
  localparam int PW    = $clog2(NK);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   w [TOTAL];
  logic [IW-1:0] i;
  logic [PW-1:0] phase;
  logic [7:0]    rcon;
  logic          accept, last_word;
  logic [31:0]   temp, prev, sub_in, sub_out, t_word;

  assign accept    = start && (state != EXPAND);
  assign last_word = (state == EXPAND) && (i == IW'(TOTAL-1));

  // phase tracks i mod NK and rcon tracks Rcon[i/NK], so no divider is needed
  always_comb begin
    temp   = w[i - IW'(1)];
    prev   = w[i - IW'(NK)];
    sub_in = (phase == '0) ? {temp[23:0], temp[31:24]} : temp;
  end

  aes_sbox32 u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    t_word = temp;
    if (phase == '0)
      t_word = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && phase == PW'(NK/2))
      t_word = sub_out;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = EXPAND;
      EXPAND:     if (last_word) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == EXPAND);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned j = 0; j < TOTAL; j++) w[j] <= '0;
      i     <= '0;
      phase <= '0;
      rcon  <= 8'h01;
    end else if (accept) begin
      for (int unsigned j = 0; j < NK; j++) w[j] <= key[32*NK-1-32*j -: 32];
      for (int unsigned j = NK; j < TOTAL; j++) w[j] <= '0;
      i     <= IW'(NK);
      phase <= '0;
      rcon  <= 8'h01;
    end else if (state == EXPAND) begin
      w[i] <= prev ^ t_word;
      i    <= i + IW'(1);
      if (phase == PW'(NK-1)) phase <= '0;
      else                    phase <= phase + PW'(1);
      if (phase == '0)
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  always_comb begin
    ExpandedKeys = '0;
    for (int unsigned j = 0; j < TOTAL; j++)
      ExpandedKeys[TOTAL*32-1-32*j -: 32] = w[j];
  end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq: AES-128/192/256 FIPS-197 vectors
// plus restart-ignore, mid-expansion reset and re-start-after-done sequences.

module tb_aes_key_expand_seq;
  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   start_s, busy_s, done_s;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [1407:0] ek128;
  logic [1663:0] ek192;
  logic [1919:0] ek256;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_key_expand_seq #(.NR(10), .NK(4)) u128 (
    .clk(clk), .reset(reset), .start(start_s[0]), .key(key128),
    .ExpandedKeys(ek128), .busy(busy_s[0]), .done(done_s[0]));
  aes_key_expand_seq #(.NR(12), .NK(6)) u192 (
    .clk(clk), .reset(reset), .start(start_s[1]), .key(key192),
    .ExpandedKeys(ek192), .busy(busy_s[1]), .done(done_s[1]));
  aes_key_expand_seq #(.NR(14), .NK(8)) u256 (
    .clk(clk), .reset(reset), .start(start_s[2]), .key(key256),
    .ExpandedKeys(ek256), .busy(busy_s[2]), .done(done_s[2]));

  typedef struct {
    int           sel;
    logic [255:0] key;
    int           lat;
    logic [31:0]  wnk;
    logic [127:0] last;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_wnk(input int sel);
    case (sel)
      0:       return ek128[1407-128 -: 32];
      1:       return ek192[1663-192 -: 32];
      default: return ek256[1919-256 -: 32];
    endcase
  endfunction

  function automatic logic [127:0] get_last(input int sel);
    case (sel)
      0:       return ek128[127:0];
      1:       return ek192[127:0];
      default: return ek256[127:0];
    endcase
  endfunction

  task automatic pulse(input int sel);
    start_s[sel] = 1'b1;
    @(posedge clk); #1;
    start_s[sel] = 1'b0;
  endtask

  // Called just after the start edge; counts edges until done, bounded.
  task automatic wait_done(input int sel, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (lat < 200 && !done_s[sel]) begin
      if (busy_s[sel]) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bc;

    vecs[0] = '{0, {128'h0, K1}, 40, 32'ha0fafe17, K1_LAST};
    vecs[1] = '{1, {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b},
                46, 32'hfe0c91f7, 128'he98ba06f448c773c8ecc720401002202};
    vecs[2] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                52, 32'h9ba35411, 128'hfe4890d1e6188d0b046df344706c631e};

    reset = 1'b1; start_s = '0; key128 = '0; key192 = '0; key256 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ek128_zero", 256'(ek128 == '0), 256'd1);
    check("rst_ek192_zero", 256'(ek192 == '0), 256'd1);
    check("rst_ek256_zero", 256'(ek256 == '0), 256'd1);
    check("rst_busy", 256'(busy_s), 256'd0);
    check("rst_done", 256'(done_s), 256'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) begin
      case (vecs[v].sel)
        0:       key128 = vecs[v].key[127:0];
        1:       key192 = vecs[v].key[191:0];
        default: key256 = vecs[v].key;
      endcase
      pulse(vecs[v].sel);
      check($sformatf("v%0d_start_busy", v), 256'(busy_s[vecs[v].sel]), 256'd1);
      wait_done(vecs[v].sel, lat, bc);
      check($sformatf("v%0d_latency", v), 256'(lat), 256'(vecs[v].lat));
      check($sformatf("v%0d_busy_cycles", v), 256'(bc), 256'(vecs[v].lat));
      check($sformatf("v%0d_busy_low", v), 256'(busy_s[vecs[v].sel]), 256'd0);
      check($sformatf("v%0d_wnk", v), 256'(get_wnk(vecs[v].sel)), 256'(vecs[v].wnk));
      check($sformatf("v%0d_last", v), 256'(get_last(vecs[v].sel)), 256'(vecs[v].last));
    end
    check("v0_msb_key", 256'(ek128[1407 -: 128]), 256'(K1));
    check("v2_msb_key", ek256[1919 -: 256], vecs[2].key);

    // Restart attempt at cycle 10 with another key must be ignored.
    key128 = K1;
    pulse(0);
    lat = 0; bc = 0;
    while (lat < 200 && !done_s[0]) begin
      if (busy_s[0]) bc++;
      if (lat == 9) begin
        start_s[0] = 1'b1;
        key128     = K2;
      end
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      lat++;
    end
    check("restart_latency", 256'(lat), 256'd40);
    check("restart_busy_cycles", 256'(bc), 256'd40);
    check("restart_last", 256'(ek128[127:0]), 256'(K1_LAST));
    check("restart_msb_key", 256'(ek128[1407 -: 128]), 256'(K1));

    // Reset at cycle 20 abandons the expansion.
    key128 = K1;
    pulse(0);
    repeat (19) @(posedge clk);
    #1;
    check("midrst_busy_before", 256'(busy_s[0]), 256'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_ek_zero", 256'(ek128 == '0), 256'd1);
    check("midrst_busy", 256'(busy_s[0]), 256'd0);
    check("midrst_done", 256'(done_s[0]), 256'd0);
    @(posedge clk); #1;
    pulse(0);
    wait_done(0, lat, bc);
    check("postrst_latency", 256'(lat), 256'd40);
    check("postrst_last", 256'(ek128[127:0]), 256'(K1_LAST));

    // New start accepted from DONE; done drops at the start edge.
    check("redo_done_before", 256'(done_s[0]), 256'd1);
    key128 = K2;
    pulse(0);
    check("redo_done_drop", 256'(done_s[0]), 256'd0);
    check("redo_busy", 256'(busy_s[0]), 256'd1);
    wait_done(0, lat, bc);
    check("redo_latency", 256'(lat), 256'd40);
    check("redo_last", 256'(ek128[127:0]), 256'h13111d7fe3944a17f307a78b4d2b30c5);
    check("redo_msb_key", 256'(ek128[1407 -: 128]), 256'(K2));
    check("both_never", 256'(busy_s & done_s), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
